exec_unit_mc: RTL

- Parametrised, multi-cycle successor to the 16-bit execution stage of our MIPS datapath.
- Single-cycle ALU, I/O and store ops complete in one cycle; MUL and DIVU run iteratively over WIDTH cycles.
- A valid/busy handshake lets the decode stage stall on long ops.
- Sits between decode (A, B, op_dec) and memory/write-back (ans_ex, ans_hi, DM_data, data_out, flag_ex).

---
 rtl/exec_pkg.sv | 30 +++
 rtl/iter_muldiv.sv | 125 ++++++++++++
 rtl/exec_unit_mc.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared opcodes, iterative-unit FSM encoding and flag bit positions for exec_unit_mc.
// Also used by iter_muldiv.
package exec_pkg;

   localparam logic [5:0] OP_ADD  = 6'd0;
   localparam logic [5:0] OP_SUB  = 6'd1;
   localparam logic [5:0] OP_AND  = 6'd2;
   localparam logic [5:0] OP_OR   = 6'd3;
   localparam logic [5:0] OP_XOR  = 6'd4;
   localparam logic [5:0] OP_NOT  = 6'd5;
   localparam logic [5:0] OP_SLL  = 6'd6;
   localparam logic [5:0] OP_SRL  = 6'd7;
   localparam logic [5:0] OP_SRA  = 6'd8;
   localparam logic [5:0] OP_MOVB = 6'd9;
   localparam logic [5:0] OP_IN   = 6'd10;
   localparam logic [5:0] OP_OUT  = 6'd11;
   localparam logic [5:0] OP_ST   = 6'd12;
   localparam logic [5:0] OP_MUL  = 6'd13;
   localparam logic [5:0] OP_DIVU = 6'd14;

   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_Z = 0;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDiv  = 2'd2
   } md_state_e;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one bit per cycle.
// The divider exists only when EXEC_DIV_EN is defined.
module iter_muldiv #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mul_i,
   input  logic             start_div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] res_lo_o,
   output logic [WIDTH-1:0] res_hi_o
);
   import exec_pkg::*;

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   md_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic [WIDTH:0]   mul_sum;

   // hi:lo holds partial product : remaining multiplier bits
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH + 1){1'b0}});

`ifdef EXEC_DIV_EN
   logic [WIDTH:0]   div_trial;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;

   // hi:lo holds partial remainder : dividend bits still to shift in / quotient bits
   assign div_trial = {hi_q, lo_q[WIDTH-1]};
   assign div_ge    = div_trial >= {1'b0, b_q};
   assign div_diff  = div_trial[WIDTH-1:0] - b_q;
`endif

   always_comb begin
      step_hi = hi_q;
      step_lo = lo_q;
      case (state_q)
         StMul: begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
         end
`ifdef EXEC_DIV_EN
         StDiv: begin
            step_hi = div_ge ? div_diff : div_trial[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      case (state_q)
         StIdle: begin
            if (start_mul_i) begin
               state_d = StMul;
               cnt_d   = CW'(WIDTH);
               hi_d    = '0;
               lo_d    = a_i;
               b_d     = b_i;
            end
`ifdef EXEC_DIV_EN
            else if (start_div_i) begin
               state_d = StDiv;
               cnt_d   = CW'(WIDTH);
               hi_d    = '0;
               lo_d    = a_i;
               b_d     = b_i;
            end
`endif
         end
         StMul, StDiv: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         b_q     <= b_d;
      end
   end

   `ifndef EXEC_DIV_EN
   logic unused_start_div;
   assign unused_start_div = start_div_i;
   `endif

   assign busy_o   = (state_q != StIdle);
   // Final step result is presented combinationally so the owner registers it on the last edge
   assign done_o   = busy_o && (cnt_q == CW'(1));
   assign res_lo_o = step_lo;
   assign res_hi_o = step_hi;

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle execution stage: single-cycle ALU/IO/store ops plus iterative MUL and DIVU.
// Define EXEC_DIV_EN to include the divider; otherwise DIVU reports an error.
module exec_unit_mc #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] data_in,
   input  logic [5:0]       op_dec,
   input  logic             op_valid,
   output logic             busy,
   output logic             ex_valid,
   output logic [WIDTH-1:0] ans_ex,
   output logic [WIDTH-1:0] ans_hi,
   output logic [WIDTH-1:0] DM_data,
   output logic [WIDTH-1:0] data_out,
   output logic [1:0]       flag_ex,
   output logic             ex_err
);
   import exec_pkg::*;

   logic [WIDTH-1:0] ans_ex_q, ans_ex_d;
   logic [WIDTH-1:0] ans_hi_q, ans_hi_d;
   logic [WIDTH-1:0] dm_data_q, dm_data_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [1:0]       flag_q, flag_d;
   logic             ex_valid_q, ex_valid_d;
   logic             ex_err_q, ex_err_d;

   logic             accept;
   logic             start_mul, start_div;
   logic             md_busy, md_done;
   logic [WIDTH-1:0] md_lo, md_hi;
   logic [WIDTH:0]   add_res, sub_res;
   logic [SHW-1:0]   shamt;
   logic             upd_z;

   assign accept    = op_valid && !md_busy;
   assign shamt     = B[SHW-1:0];
   assign add_res   = {1'b0, A} + {1'b0, B};
   assign sub_res   = {1'b0, A} - {1'b0, B};
   assign start_mul = accept && (op_dec == OP_MUL);
`ifdef EXEC_DIV_EN
   assign start_div = accept && (op_dec == OP_DIVU) && (B != '0);
`else
   assign start_div = 1'b0;
`endif

   iter_muldiv #(
      .WIDTH(WIDTH)
   ) u_iter_muldiv (
      .clk        (clk),
      .reset      (reset),
      .start_mul_i(start_mul),
      .start_div_i(start_div),
      .a_i        (A),
      .b_i        (B),
      .busy_o     (md_busy),
      .done_o     (md_done),
      .res_lo_o   (md_lo),
      .res_hi_o   (md_hi)
   );

   always_comb begin
      ans_ex_d   = ans_ex_q;
      ans_hi_d   = ans_hi_q;
      dm_data_d  = dm_data_q;
      data_out_d = data_out_q;
      flag_d     = flag_q;
      ex_valid_d = 1'b0;
      ex_err_d   = 1'b0;
      upd_z      = 1'b0;
      if (md_done) begin
         ans_ex_d   = md_lo;
         ans_hi_d   = md_hi;
         ex_valid_d = 1'b1;
         upd_z      = 1'b1;
      end else if (accept) begin
         ex_valid_d = 1'b1;
         ans_hi_d   = '0;
         case (op_dec)
            OP_ADD: begin
               ans_ex_d       = add_res[WIDTH-1:0];
               flag_d[FLAG_C] = add_res[WIDTH];
               upd_z          = 1'b1;
            end
            OP_SUB: begin
               ans_ex_d       = sub_res[WIDTH-1:0];
               flag_d[FLAG_C] = sub_res[WIDTH];
               upd_z          = 1'b1;
            end
            OP_AND: begin ans_ex_d = A & B;              upd_z = 1'b1; end
            OP_OR:  begin ans_ex_d = A | B;              upd_z = 1'b1; end
            OP_XOR: begin ans_ex_d = A ^ B;              upd_z = 1'b1; end
            OP_NOT: begin ans_ex_d = ~A;                 upd_z = 1'b1; end
            OP_SLL: begin ans_ex_d = A << shamt;         upd_z = 1'b1; end
            OP_SRL: begin ans_ex_d = A >> shamt;         upd_z = 1'b1; end
            OP_SRA: begin ans_ex_d = $signed(A) >>> shamt; upd_z = 1'b1; end
            OP_MOVB: ans_ex_d   = B;
            OP_IN:   ans_ex_d   = data_in;
            OP_OUT:  data_out_d = A;
            OP_ST: begin
               dm_data_d = B;
               ans_ex_d  = A;
            end
            OP_MUL: begin
               ex_valid_d = 1'b0;
               ans_hi_d   = ans_hi_q;
            end
            OP_DIVU: begin
`ifdef EXEC_DIV_EN
               if (B == '0) begin
                  ans_ex_d = '1;
                  ans_hi_d = A;
                  ex_err_d = 1'b1;
                  upd_z    = 1'b1;
               end else begin
                  ex_valid_d = 1'b0;
                  ans_hi_d   = ans_hi_q;
               end
`else
               ans_ex_d = '1;
               ex_err_d = 1'b1;
`endif
            end
            default: ans_hi_d = ans_hi_q;  // NOP: only ex_valid
         endcase
      end
      if (upd_z) begin
         flag_d[FLAG_Z] = (ans_ex_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ans_ex_q   <= '0;
         ans_hi_q   <= '0;
         dm_data_q  <= '0;
         data_out_q <= '0;
         flag_q     <= '0;
         ex_valid_q <= 1'b0;
         ex_err_q   <= 1'b0;
      end else begin
         ans_ex_q   <= ans_ex_d;
         ans_hi_q   <= ans_hi_d;
         dm_data_q  <= dm_data_d;
         data_out_q <= data_out_d;
         flag_q     <= flag_d;
         ex_valid_q <= ex_valid_d;
         ex_err_q   <= ex_err_d;
      end
   end

   assign busy     = md_busy;
   assign ex_valid = ex_valid_q;
   assign ans_ex   = ans_ex_q;
   assign ans_hi   = ans_hi_q;
   assign DM_data  = dm_data_q;
   assign data_out = data_out_q;
   assign flag_ex  = flag_q;
   assign ex_err   = ex_err_q;

endmodule
